// File: rtl/wired_wkupdreg_mo.sv
// Issue-to-FU1 operand register: captures SEL operands and wakeup selects, merges
// forwarded results in FU1, and freezes the merged values while FU1 is stalled.
module wired_wkupdreg_mo #(
  parameter int OPND_CNT       = 2,
  parameter int DATA_W         = 32,
  parameter int WAKEUP_SRC_CNT = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [OPND_CNT*WAKEUP_SRC_CNT-1:0] wkup_src_i,
  input  logic [OPND_CNT*DATA_W-1:0]         data_i,
  input  logic [WAKEUP_SRC_CNT*DATA_W-1:0]   wkup_data_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [OPND_CNT*DATA_W-1:0]         data_o,
  output logic [OPND_CNT-1:0]                fwd_hit_o
);

  // Handshake: ready_o = !valid_q | ready_i; accept = valid_i & ready_o & !flush_i;
  // consume = valid_o & ready_i. An entry moves only on a cycle where both sides agree.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FWD   = 2'd1,
    ST_HELD  = 2'd2
  } entry_state_e;

  entry_state_e entry_state;

  logic                                          valid_q, valid_d;
  logic [OPND_CNT-1:0][WAKEUP_SRC_CNT-1:0]       src_q, src_d;
  logic [OPND_CNT-1:0][DATA_W-1:0]               data_q, data_d;
  logic [OPND_CNT-1:0][DATA_W-1:0]               merged;
  logic [OPND_CNT-1:0][WAKEUP_SRC_CNT-1:0]       src_in;
  logic [OPND_CNT-1:0][DATA_W-1:0]               data_in;
  logic [WAKEUP_SRC_CNT-1:0][DATA_W-1:0]         wkup_data;
  logic                                          any_src;
  logic                                          accept;
  logic                                          consume;
  logic                                          stall;

  assign src_in    = wkup_src_i;
  assign data_in   = data_i;
  assign wkup_data = wkup_data_i;

  always_comb begin
    any_src = 1'b0;
    for (int o = 0; o < OPND_CNT; o++) begin
      any_src = any_src | (|src_q[o]);
    end
    if (!valid_q) begin
      entry_state = ST_EMPTY;
    end else if (any_src) begin
      entry_state = ST_FWD;
    end else begin
      entry_state = ST_HELD;
    end
  end

  // Multi-hot selects OR together; SEL promises one-hot so no error is raised.
  always_comb begin
    for (int o = 0; o < OPND_CNT; o++) begin
      merged[o] = '0;
      if (|src_q[o]) begin
        for (int i = 0; i < WAKEUP_SRC_CNT; i++) begin
          if (src_q[o][i]) begin
            merged[o] = merged[o] | wkup_data[i];
          end
        end
      end else begin
        merged[o] = data_q[o];
      end
      fwd_hit_o[o] = valid_q & (|src_q[o]);
    end
  end

  assign ready_o = (entry_state == ST_EMPTY) | ready_i;
  assign valid_o = valid_q;
  assign data_o  = merged;
  assign accept  = valid_i & ready_o & ~flush_i;
  assign consume = valid_q & ready_i;
  assign stall   = (entry_state != ST_EMPTY) & ~ready_i;

  always_comb begin
    valid_d = valid_q;
    src_d   = src_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      src_d   = '0;
    end else if (accept) begin
      valid_d = 1'b1;
      src_d   = src_in;
      data_d  = data_in;
    end else if (stall) begin
      // Forwarded values exist for one cycle only, so freeze them now.
      src_d  = '0;
      data_d = merged;
    end else if (consume) begin
      valid_d = 1'b0;
      src_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      src_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      src_q   <= src_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_wired_wkupdreg_mo.sv
// Directed bench for wired_wkupdreg_mo: reset, plain accept, forwarding, stall hold,
// back-to-back throughput, flush and asynchronous reset.
module tb_wired_wkupdreg_mo;

  localparam int OPND_CNT       = 2;
  localparam int DATA_W         = 32;
  localparam int WAKEUP_SRC_CNT = 4;

  logic                               clk;
  logic                               rst_n;
  logic                               flush_i;
  logic                               valid_i;
  logic                               ready_o;
  logic [OPND_CNT*WAKEUP_SRC_CNT-1:0] wkup_src_i;
  logic [OPND_CNT*DATA_W-1:0]         data_i;
  logic [WAKEUP_SRC_CNT*DATA_W-1:0]   wkup_data_i;
  logic                               valid_o;
  logic                               ready_i;
  logic [OPND_CNT*DATA_W-1:0]         data_o;
  logic [OPND_CNT-1:0]                fwd_hit_o;

  int checks;
  int errors;

  wired_wkupdreg_mo #(
    .OPND_CNT      (OPND_CNT),
    .DATA_W        (DATA_W),
    .WAKEUP_SRC_CNT(WAKEUP_SRC_CNT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .wkup_src_i (wkup_src_i),
    .data_i     (data_i),
    .wkup_data_i(wkup_data_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .fwd_hit_o  (fwd_hit_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wkup(input int idx, input logic [DATA_W-1:0] val);
    wkup_data_i[idx*DATA_W +: DATA_W] = val;
  endtask

  initial begin
    logic [DATA_W-1:0] exp_op0;
    logic [DATA_W-1:0] exp_op1;
    logic [1:0]        exp_hit;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    valid_i     = 1'b0;
    ready_i     = 1'b0;
    wkup_src_i  = '0;
    data_i      = '0;
    wkup_data_i = '0;

    // Reset state
    @(negedge clk);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_hit", 64'(fwd_hit_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Accept with no forward
    valid_i    = 1'b1;
    wkup_src_i = 8'h00;
    data_i     = {32'h22, 32'h11};
    ready_i    = 1'b1;
    @(negedge clk);
    check("plain_ready", 64'(ready_o), 64'd1);
    tick();
    valid_i = 1'b0;
    @(negedge clk);
    check("plain_valid", 64'(valid_o), 64'd1);
    check("plain_data", data_o, {32'h22, 32'h11});
    check("plain_hit", 64'(fwd_hit_o), 64'd0);
    tick();
    @(negedge clk);
    check("plain_drain", 64'(valid_o), 64'd0);

    // Forward merge on operand 0 from source 2
    tick();
    valid_i    = 1'b1;
    wkup_src_i = {4'b0000, 4'b0100};
    data_i     = {32'h44, 32'h33};
    tick();
    valid_i = 1'b0;
    set_wkup(0, 32'h0101_0101);
    set_wkup(1, 32'h0202_0202);
    set_wkup(2, 32'hDEAD_0000);
    set_wkup(3, 32'h0808_0808);
    @(negedge clk);
    check("fwd_valid", 64'(valid_o), 64'd1);
    check("fwd_data", data_o, {32'h44, 32'hDEAD_0000});
    check("fwd_hit", 64'(fwd_hit_o), 64'b01);
    tick();
    @(negedge clk);
    check("fwd_drain", 64'(valid_o), 64'd0);

    // Stall hold: forwarded value captured once, later wakeup changes ignored
    tick();
    valid_i    = 1'b1;
    wkup_src_i = {4'b0000, 4'b0100};
    data_i     = {32'h66, 32'h55};
    ready_i    = 1'b0;
    tick();
    valid_i    = 1'b1;
    wkup_src_i = {4'b0001, 4'b0001};
    data_i     = {32'hBAD1, 32'hBAD0};
    set_wkup(2, 32'hDEAD_0000);
    @(negedge clk);
    check("stall1_valid", 64'(valid_o), 64'd1);
    check("stall1_data", data_o, {32'h66, 32'hDEAD_0000});
    check("stall1_hit", 64'(fwd_hit_o), 64'b01);
    check("stall1_ready", 64'(ready_o), 64'd0);
    tick();
    set_wkup(2, 32'h0000_BEEF);
    @(negedge clk);
    check("stall2_valid", 64'(valid_o), 64'd1);
    check("stall2_data", data_o, {32'h66, 32'hDEAD_0000});
    check("stall2_hit", 64'(fwd_hit_o), 64'b00);
    check("stall2_ready", 64'(ready_o), 64'd0);
    tick();
    @(negedge clk);
    check("stall3_data", data_o, {32'h66, 32'hDEAD_0000});
    check("stall3_hit", 64'(fwd_hit_o), 64'b00);
    tick();
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    check("release_ready", 64'(ready_o), 64'd1);
    check("release_data", data_o, {32'h66, 32'hDEAD_0000});
    tick();
    @(negedge clk);
    check("release_once", 64'(valid_o), 64'd0);

    // Full throughput: 8 entries, odd ones forward operand 1
    for (int s = 0; s < WAKEUP_SRC_CNT; s++) begin
      set_wkup(s, 32'hA000_0000 | 32'(s));
    end
    for (int k = 0; k <= 8; k++) begin
      tick();
      if (k < 8) begin
        valid_i    = 1'b1;
        data_i     = {32'h200 + 32'(k), 32'h100 + 32'(k)};
        wkup_src_i = (k % 2 == 1) ? {4'(4'b0001 << ((k / 2) % 4)), 4'b0000} : 8'h00;
      end else begin
        valid_i    = 1'b0;
        wkup_src_i = 8'h00;
      end
      @(negedge clk);
      check("tput_ready", 64'(ready_o), 64'd1);
      if (k > 0) begin
        exp_op0 = 32'h100 + 32'(k - 1);
        exp_op1 = ((k - 1) % 2 == 1) ? (32'hA000_0000 | 32'(((k - 1) / 2) % 4)) : 32'h200 + 32'(k - 1);
        exp_hit = ((k - 1) % 2 == 1) ? 2'b10 : 2'b00;
        check("tput_valid", 64'(valid_o), 64'd1);
        check("tput_data", data_o, {exp_op1, exp_op0});
        check("tput_hit", 64'(fwd_hit_o), 64'(exp_hit));
      end
    end
    tick();
    @(negedge clk);
    check("tput_drain", 64'(valid_o), 64'd0);

    // Flush a stalled FWD entry while a new entry is offered
    tick();
    valid_i    = 1'b1;
    wkup_src_i = {4'b0000, 4'b0100};
    data_i     = {32'h88, 32'h77};
    ready_i    = 1'b0;
    tick();
    flush_i    = 1'b1;
    valid_i    = 1'b1;
    wkup_src_i = 8'h00;
    data_i     = {32'hCC, 32'hBB};
    @(negedge clk);
    check("flush_ready", 64'(ready_o), 64'd0);
    check("flush_pre_hit", 64'(fwd_hit_o), 64'b01);
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("flush_valid", 64'(valid_o), 64'd0);
    check("flush_hit", 64'(fwd_hit_o), 64'd0);
    check("flush_data", data_o, {32'h88, 32'h77});
    tick();
    @(negedge clk);
    check("flush_nocap", 64'(valid_o), 64'd0);

    // Asynchronous reset while HELD
    tick();
    valid_i    = 1'b1;
    wkup_src_i = 8'h00;
    data_i     = {32'hAA, 32'h99};
    ready_i    = 1'b0;
    tick();
    valid_i = 1'b0;
    tick();
    @(negedge clk);
    check("held_valid", 64'(valid_o), 64'd1);
    check("held_data", data_o, {32'hAA, 32'h99});
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(valid_o), 64'd0);
    check("arst_data", data_o, 64'd0);
    check("arst_hit", 64'(fwd_hit_o), 64'd0);
    check("arst_ready", 64'(ready_o), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wired_wkupdreg_mo.md
Name: wired_wkupdreg_mo

Overview:
- Multi-operand, handshaked successor to the single-operand issue-stage wakeup data register.
- Sits between IQ select (SEL) and the first FU stage (FU1).
- Captures operand data and per-operand wakeup-source selects at SEL, then merges same-cycle forwarded results in FU1.
- Holds merged values across FU1 back-pressure. Adds a valid/ready handshake, flush, and per-operand forward-hit reporting.

Parameters:
- OPND_CNT, 2, number of source operands handled in parallel.
- DATA_W, 32, operand data width.
- WAKEUP_SRC_CNT, 4, number of wakeup/forward sources.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_i  in  1  pipeline flush; kills the held entry.
- valid_i  in  1  SEL entry valid.
- ready_o  out  1  block can accept a SEL entry.
- wkup_src_i  in  OPND_CNT*WAKEUP_SRC_CNT  per-operand forward select, SEL cycle.
- data_i  in  OPND_CNT*DATA_W  per-operand register-file/IQ data, SEL cycle.
- wkup_data_i  in  WAKEUP_SRC_CNT*DATA_W  forwarded results, valid only in the cycle after acceptance.
- valid_o  out  1  FU1 entry valid.
- ready_i  in  1  downstream accepts the FU1 entry.
- data_o  out  OPND_CNT*DATA_W  merged operand data, FU1 cycle.
- fwd_hit_o  out  OPND_CNT  operand's data_o comes from wkup_data_i this cycle.

Behaviour:
- **State.**
  - valid_q: 1 bit.
  - Per operand: src_q[WAKEUP_SRC_CNT] and data_q[DATA_W].
  - The entry is effectively a 3-state FSM: EMPTY (valid_q=0); FWD (valid_q=1, any src_q bit set); HELD (valid_q=1, all src_q=0).
- **Reset (async, rst_n=0).**
  - valid_q=0, all src_q=0, all data_q=0.
  - Hence valid_o=0, data_o=0, fwd_hit_o=0, ready_o=1.
- **Handshake.**
  - ready_o = !valid_q | ready_i.
  - accept = valid_i & ready_o & !flush_i.
  - consume = valid_o & ready_i.
- **Accept (next edge).**
  - valid_q<=1; src_q<=wkup_src_i; data_q<=data_i.
  - Latency SEL to FU1 is 1 cycle.
  - Back-to-back accept while the current entry is consumed in the same cycle is allowed: full throughput.
- **Merge (combinational, per operand).**
  - data_o = (|src_q) ? OR over i of (src_q[i] ? wkup_data_i[i] : 0) : data_q.
  - fwd_hit_o = valid_q & |src_q.
  - A multi-hot src_q is OR-merged. SEL guarantees one-hot; multi-hot is not flagged.
- **Stall capture.**
  - Condition: valid_q & !ready_i & !flush_i.
  - Next edge: data_q<=data_o for every operand, all src_q<=0, valid_q stays 1 (FWD→HELD, or HELD→HELD).
  - Forwarded data is sampled exactly once, in the first FU1 cycle, and wkup_data_i is ignored afterwards.
- **Consume without new accept.** valid_q<=0 and src_q<=0. data_q keeps its value (don't-care).
- **Flush.**
  - Highest priority: next edge valid_q<=0, src_q<=0, data_q unchanged.
  - A valid_i in the same cycle is dropped; ready_o is unaffected.
- **data_o when valid_o=0.** Equals data_q, since src_q=0. Deterministic, not meaningful.
- **Reset mid-FWD.** The entry is lost and outputs return to reset values immediately.
- **Timing.** No combinational path from valid_i or data_i to outputs. ready_o depends only on valid_q and ready_i.

Test Plan:
- **Reset, then accept with no forward.** valid_i=1, src=0, data_i={0x11,0x22}, ready_i=1 → next cycle valid_o=1, data_o={0x11,0x22}, fwd_hit_o=00.
- **Forward merge.** Op0 src=0b0100, op1 src=0; wkup_data_i[2]=0xDEAD0000 in FU1 cycle → data_o[0]=0xDEAD0000, data_o[1]=data_i[1], fwd_hit_o=01.
- **Stall hold.** As previous but ready_i=0 for 3 cycles; wkup_data_i[2] changes to 0xBEEF after cycle 1 → data_o[0] stays 0xDEAD0000, fwd_hit_o=00 from cycle 2, valid_o held, ready_o=0. On ready_i=1 the entry is consumed once.
- **Full throughput.** 8 back-to-back entries with ready_i=1 and alternating forward/no-forward → 8 outputs on 8 consecutive cycles, in order, correct values, ready_o constantly 1.
- **Flush.** Flush_i during a stalled FWD entry with valid_i=1 → next cycle valid_o=0, fwd_hit_o=0. The incoming entry is not captured.
- **Async reset.** Assert rst_n=0 mid-cycle while HELD → valid_o=0 and data_o=0 immediately, without waiting for a clock edge.
